// File: rtl/dwfsm_writeback.sv
// Hash writeback sequencer: captures a 512-bit Keccak hash and streams it
// to the OCM bus master as four 128-bit beats, low beat first, then waits
// for the master's burst completion before advancing the block index.
module dwfsm_writeback #(
  parameter logic [31:0] BASE_INDEX = 32'd0,
  parameter int          NUM_TXN    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] hash_data,
  input  logic         hash_valid,
  output logic         hash_ready,
  output logic [127:0] wr_data,
  output logic         wr_data_valid,
  input  logic         bus_wr_ready,
  output logic [31:0]  write_addr_index,
  output logic         init_master_txn,
  input  logic         write_done,
  output logic         busy,
  output logic         txn_done
);

  typedef enum logic [1:0] {IDLE, START, BEAT, WAIT_DONE} state_t;

  state_t         state, state_nx;
  logic [511:0]   shadow;
  logic [1:0]     beat;
  logic [31:0]    txn_cnt;
  logic           accept, beat_xfer, done_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and outputs. hash_ready is gated by reset so it stays low
  // during reset, and by txn_done so a hash offered in the completion
  // cycle waits one more IDLE cycle.
  always_comb begin
    state_nx        = state;
    hash_ready      = 1'b0;
    init_master_txn = 1'b0;
    wr_data_valid   = 1'b0;
    wr_data         = '0;
    busy            = (state != IDLE);
    accept          = 1'b0;
    beat_xfer       = 1'b0;
    done_hit        = 1'b0;
    case (state)
      IDLE: begin
        hash_ready = reset && !txn_done && (txn_cnt < 32'(NUM_TXN));
        accept     = hash_valid && hash_ready;
        if (accept) state_nx = START;
      end
      START: begin
        init_master_txn = 1'b1;
        state_nx        = BEAT;
      end
      BEAT: begin
        wr_data_valid = 1'b1;
        wr_data       = shadow[{beat, 7'd0} +: 128];
        beat_xfer     = bus_wr_ready;
        if (beat_xfer && beat == 2'd3) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        done_hit = write_done;
        if (done_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: shadow capture, beat counter, block index and txn count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow           <= '0;
      beat             <= '0;
      txn_cnt          <= '0;
      write_addr_index <= BASE_INDEX;
      txn_done         <= 1'b0;
    end else begin
      txn_done <= done_hit;
      if (accept) begin
        shadow <= hash_data;
        beat   <= '0;
      end
      if (beat_xfer) beat <= beat + 2'd1;
      if (done_hit) begin
        write_addr_index <= write_addr_index + 32'd1;
        txn_cnt          <= txn_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dwfsm_writeback.sv
// Directed bench for dwfsm_writeback. A second instance with the top block
// index shares all inputs so the index wrap can be observed alongside.
module tb_dwfsm_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] hash_data;
  logic         hash_valid, bus_wr_ready, write_done;
  logic         hash_ready, wr_data_valid, init_master_txn, busy, txn_done;
  logic [127:0] wr_data;
  logic [31:0]  write_addr_index;
  logic         hash_ready_w, wr_data_valid_w, init_master_txn_w, busy_w, txn_done_w;
  logic [127:0] wr_data_w;
  logic [31:0]  write_addr_index_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dwfsm_writeback dut (
    .clk(clk), .reset(reset), .hash_data(hash_data), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .bus_wr_ready(bus_wr_ready), .write_addr_index(write_addr_index),
    .init_master_txn(init_master_txn), .write_done(write_done), .busy(busy),
    .txn_done(txn_done)
  );

  dwfsm_writeback #(.BASE_INDEX(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .hash_data(hash_data), .hash_valid(hash_valid),
    .hash_ready(hash_ready_w), .wr_data(wr_data_w), .wr_data_valid(wr_data_valid_w),
    .bus_wr_ready(bus_wr_ready), .write_addr_index(write_addr_index_w),
    .init_master_txn(init_master_txn_w), .write_done(write_done), .busy(busy_w),
    .txn_done(txn_done_w)
  );

  function automatic logic [511:0] mk_hash(input logic [7:0] base);
    logic [511:0] h;
    for (int i = 0; i < 64; i++) h[8*i +: 8] = base + 8'(i);
    return h;
  endfunction

  task automatic tk;
    @(posedge clk); #1;
  endtask

  // Offer a hash and return in the START cycle (inputs point, +1 after edge).
  task automatic start_txn(input logic [511:0] h);
    int n;
    hash_data = h; hash_valid = 1'b1; bus_wr_ready = 1'b1;
    #1;
    n = 0;
    while (hash_ready !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    checks++;
    if (n == 20) begin errors++; $display("FAIL accept_timeout: hash_ready=%b required 1", hash_ready); end
    @(posedge clk); #1;
    hash_valid = 1'b0;
    hash_data  = ~h;
  endtask

  task automatic test_reset;
    reset = 1'b0; hash_valid = 1'b0; hash_data = '0; bus_wr_ready = 1'b0; write_done = 1'b0;
    tk(); tk();
    #1;
    checks++; if ({wr_data_valid, init_master_txn, txn_done, busy, hash_ready} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b required 00000", {wr_data_valid, init_master_txn, txn_done, busy, hash_ready}); end
    checks++; if (wr_data !== 128'h0) begin errors++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
    checks++; if (write_addr_index !== 32'h0) begin errors++; $display("FAIL reset_index: got %h required 0", write_addr_index); end
    checks++; if (write_addr_index_w !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_index_w: got %h required ffffffff", write_addr_index_w); end
    tk();
    reset = 1'b1;
    #1;
    checks++; if (hash_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", hash_ready); end
  endtask

  task automatic test_basic;
    logic [127:0] eb [4];
    eb = '{128'h0F0E0D0C0B0A09080706050403020100, 128'h1F1E1D1C1B1A19181716151413121110,
           128'h2F2E2D2C2B2A29282726252423222120, 128'h3F3E3D3C3B3A39383736353433323130};
    start_txn(mk_hash(8'h00));
    #1;
    checks++; if ({init_master_txn, busy, hash_ready, wr_data_valid} !== 4'b1100) begin errors++; $display("FAIL basic_start: got %b required 1100", {init_master_txn, busy, hash_ready, wr_data_valid}); end
    tk();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (wr_data_valid !== 1'b1 || init_master_txn !== 1'b0) begin errors++; $display("FAIL basic_valid%0d: valid=%b init=%b required 1 0", k, wr_data_valid, init_master_txn); end
      checks++; if (wr_data !== eb[k]) begin errors++; $display("FAIL basic_beat%0d: got %h required %h", k, wr_data, eb[k]); end
      tk();
    end
    #1;
    checks++; if (wr_data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_t6: valid=%b busy=%b required 0 1", wr_data_valid, busy); end
    tk();
    write_done = 1'b1;
    tk();
    write_done = 1'b0; hash_valid = 1'b1; hash_data = mk_hash(8'h11);
    #1;
    checks++; if (txn_done !== 1'b1) begin errors++; $display("FAIL basic_txn_done: got %b required 1", txn_done); end
    checks++; if (write_addr_index !== 32'd1) begin errors++; $display("FAIL basic_index: got %h required 1", write_addr_index); end
    checks++; if (write_addr_index_w !== 32'd0) begin errors++; $display("FAIL wrap_index: got %h required 0", write_addr_index_w); end
    checks++; if (hash_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done_cycle: got %b required 0", hash_ready); end
    tk();
    hash_valid = 1'b0;
    #1;
    checks++; if ({txn_done, busy, hash_ready} !== 3'b001) begin errors++; $display("FAIL basic_after_done: got %b required 001", {txn_done, busy, hash_ready}); end
  endtask

  task automatic test_backpressure;
    logic [127:0] eb [4];
    logic rp [7];
    int kb;
    eb = '{128'h4F4E4D4C4B4A49484746454443424140, 128'h5F5E5D5C5B5A59585756555453525150,
           128'h6F6E6D6C6B6A69686766656463626160, 128'h7F7E7D7C7B7A79787776757473727170};
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    start_txn(mk_hash(8'h40));
    tk();
    kb = 0;
    for (int c = 0; c < 7; c++) begin
      bus_wr_ready = rp[c];
      #1;
      checks++; if (wr_data_valid !== 1'b1 || wr_data !== eb[kb]) begin errors++; $display("FAIL bp_cycle%0d: valid=%b data=%h required 1 %h", c, wr_data_valid, wr_data, eb[kb]); end
      if (rp[c]) kb++;
      tk();
    end
    bus_wr_ready = 1'b1;
    #1;
    checks++; if (wr_data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_four_beats: valid=%b busy=%b required 0 1", wr_data_valid, busy); end
    write_done = 1'b1;
    tk();
    write_done = 1'b0;
    #1;
    checks++; if (txn_done !== 1'b1 || write_addr_index !== 32'd2) begin errors++; $display("FAIL bp_done: txn_done=%b index=%h required 1 2", txn_done, write_addr_index); end
  endtask

  task automatic test_limit;
    tk();
    hash_data = mk_hash(8'h20); hash_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (hash_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL limit_cycle%0d: ready=%b busy=%b required 0 0", c, hash_ready, busy); end
      tk();
    end
    hash_valid = 1'b0;
    #1;
    checks++; if (write_addr_index !== 32'd2) begin errors++; $display("FAIL limit_index: got %h required 2", write_addr_index); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] ea [4];
    logic [127:0] eb [4];
    ea = '{128'h8F8E8D8C8B8A89888786858483828180, 128'h9F9E9D9C9B9A99989796959493929190,
           128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0};
    eb = '{128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0, 128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0,
           128'hEFEEEDECEBEAE9E8E7E6E5E4E3E2E1E0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};
    reset = 1'b0; tk(); reset = 1'b1;
    start_txn(mk_hash(8'h80));
    tk(); tk(); tk();
    #1;
    checks++; if (wr_data !== ea[2]) begin errors++; $display("FAIL mid_beat2: got %h required %h", wr_data, ea[2]); end
    reset = 1'b0;
    tk();
    #1;
    checks++; if ({wr_data_valid, init_master_txn, txn_done, busy, hash_ready} !== 5'b0 || wr_data !== 128'h0) begin errors++; $display("FAIL mid_reset_outs: got %b data=%h required 00000 0", {wr_data_valid, init_master_txn, txn_done, busy, hash_ready}, wr_data); end
    checks++; if (write_addr_index !== 32'd0) begin errors++; $display("FAIL mid_reset_index: got %h required 0", write_addr_index); end
    reset = 1'b1;
    start_txn(mk_hash(8'hC0));
    tk();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (wr_data_valid !== 1'b1 || wr_data !== eb[k]) begin errors++; $display("FAIL post_reset_beat%0d: valid=%b data=%h required 1 %h", k, wr_data_valid, wr_data, eb[k]); end
      tk();
    end
    write_done = 1'b1;
    tk();
    write_done = 1'b0;
    #1;
    checks++; if (txn_done !== 1'b1 || write_addr_index !== 32'd1) begin errors++; $display("FAIL post_reset_done: txn_done=%b index=%h required 1 1", txn_done, write_addr_index); end
  endtask

  task automatic test_spurious_done;
    logic [127:0] eb [4];
    eb = '{128'h0F0E0D0C0B0A09080706050403020100, 128'h1F1E1D1C1B1A19181716151413121110,
           128'h2F2E2D2C2B2A29282726252423222120, 128'h3F3E3D3C3B3A39383736353433323130};
    tk();
    start_txn(mk_hash(8'h00));
    tk();
    write_done = 1'b1;
    tk();
    bus_wr_ready = 1'b0;
    tk();
    write_done = 1'b0; bus_wr_ready = 1'b1;
    #1;
    checks++; if (wr_data_valid !== 1'b1 || wr_data !== eb[1]) begin errors++; $display("FAIL spur_hold: valid=%b data=%h required 1 %h", wr_data_valid, wr_data, eb[1]); end
    checks++; if (write_addr_index !== 32'd1 || txn_done !== 1'b0) begin errors++; $display("FAIL spur_index: index=%h txn_done=%b required 1 0", write_addr_index, txn_done); end
    tk(); tk(); tk();
    #1;
    checks++; if (wr_data_valid !== 1'b0 || busy !== 1'b1 || write_addr_index !== 32'd1) begin errors++; $display("FAIL spur_wait: valid=%b busy=%b index=%h required 0 1 1", wr_data_valid, busy, write_addr_index); end
    write_done = 1'b1;
    tk();
    write_done = 1'b0;
    #1;
    checks++; if (txn_done !== 1'b1 || write_addr_index !== 32'd2) begin errors++; $display("FAIL spur_done: txn_done=%b index=%h required 1 2", txn_done, write_addr_index); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_limit();
    test_reset_mid();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwfsm_writeback.md
DWFSM_WRITEBACK -- requirements
Module: dwfsm_writeback

Interface
REQ-001 SHALL have parameter BASE_INDEX, default 0: the reset value of write_addr_index.
REQ-002 SHALL have parameter NUM_TXN, default 2: the number of hash writebacks accepted after reset. Further hash_valid is ignored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset=0 resets the block).
REQ-005 SHALL have port hash_data, input, 512 bits: the finished Keccak hash to write back.
REQ-006 SHALL have port hash_valid, input, 1 bit: hash_data is valid.
REQ-007 SHALL have port hash_ready, output, 1 bit: the block can accept a hash.
REQ-008 SHALL have port wr_data, output, 128 bits: the current OCM write beat.
REQ-009 SHALL have port wr_data_valid, output, 1 bit: wr_data is valid.
REQ-010 SHALL have port bus_wr_ready, input, 1 bit: the bus master accepts a beat.
REQ-011 SHALL have port write_addr_index, output, 32 bits: the OCM block index of the current transaction.
REQ-012 SHALL have port init_master_txn, output, 1 bit: a one-cycle pulse that starts a bus write burst.
REQ-013 SHALL have port write_done, input, 1 bit: the bus master has completed the burst.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port txn_done, output, 1 bit: a one-cycle pulse when a writeback completes.

Function
REQ-016 SHALL implement states IDLE, START, BEAT and WAIT_DONE.
REQ-017 IDLE SHALL drive hash_ready=1 while the completed-transaction count is below NUM_TXN, and 0 otherwise.
REQ-018 In IDLE, hash_valid&hash_ready SHALL capture hash_data into an internal 512-bit shadow register and move to START.
REQ-019 START SHALL assert init_master_txn for exactly one cycle and move to BEAT; hash_ready SHALL be 0 outside IDLE.
REQ-020 BEAT SHALL drive wr_data=shadow[128*b+127:128*b], where b is the beat counter (0..3), and hold wr_data_valid=1.
REQ-021 Beat order SHALL be b=0 first, i.e. hash[127:0] first.
REQ-022 A beat SHALL be transferred only on a cycle with wr_data_valid&bus_wr_ready, after which b increments.
REQ-023 While bus_wr_ready=0 in BEAT, wr_data and b SHALL hold.
REQ-024 When beat 3 is transferred, the block SHALL go to WAIT_DONE with wr_data_valid=0 on the next cycle.
REQ-025 In WAIT_DONE, write_done=1 SHALL increment write_addr_index by 1 (mod 2^32, wrapping), pulse txn_done for one cycle, increment the transaction count and return to IDLE.
REQ-026 write_done SHALL be ignored in every state except WAIT_DONE.
REQ-027 Latency: for hash accept at edge T with bus_wr_ready held at 1, init_master_txn SHALL be high in cycle T+1 and beats 0..3 SHALL transfer in cycles T+2..T+5.
REQ-028 Continuing REQ-027, wr_data_valid SHALL be 0 in cycle T+6.
REQ-029 hash_data changes after capture SHALL NOT affect any in-flight beat.
REQ-030 A hash_valid that arrives in the same cycle that txn_done is asserted SHALL NOT be accepted until the next cycle in IDLE.

Reset
REQ-031 While reset=0 at a rising edge, the state SHALL go to IDLE and b and the transaction count SHALL clear.
REQ-032 While reset=0 at a rising edge, write_addr_index SHALL be set to BASE_INDEX.
REQ-033 While reset=0 at a rising edge, outputs SHALL be: wr_data=0, wr_data_valid=0, init_master_txn=0, txn_done=0, busy=0, hash_ready=0.
REQ-034 hash_ready SHALL rise in the first cycle after reset deasserts.
REQ-035 Reset applied mid-transaction SHALL abort the transaction, discard the shadow register and not increment write_addr_index.

Verification
REQ-036 Basic: hash=512'h{0..3F bytes}, bus_wr_ready=1, write_done 2 cycles after the last beat. Beats SHALL be [127:0], [255:128], [383:256], [511:384]; then write_addr_index=1 and txn_done=1 for one cycle.
REQ-037 Backpressure: bus_wr_ready toggles 1,0,0,1,0,1,1. Exactly 4 beats SHALL transfer, and wr_data SHALL be stable throughout each stall.
REQ-038 Limit: with NUM_TXN=2, three hashes are offered. Two SHALL be written; hash_ready SHALL then stay 0 and write_addr_index SHALL end at 2.
REQ-039 Spurious done: write_done is pulsed during BEAT. No state change and no index increment SHALL occur.
REQ-040 Reset at beat 2: reset=0 for 1 cycle. SHALL return to IDLE with all outputs 0 and write_addr_index=BASE_INDEX; a new hash SHALL then write 4 beats correctly.
REQ-041 Wrap: with BASE_INDEX=32'hFFFFFFFF, one writeback SHALL leave write_addr_index=0.
